gpio_port_bank: RTL and testbench

- Parametrised successor to the single fake bidirectional port: NUM_PORTS ports, each WIDTH bits, behind one decoder on the core's external peripheral bus.
- Each port has TRIS and PORT latches, a two-flop input synchroniser and PIC-style interrupt-on-change (IOC) on a per-pin mask.
- Sits between picmicro_midrange_core's extern_peripherals bus and the board pins.
- Drives one IOC interrupt strobe per port plus a hit flag, so the top-level mux can OR it with other peripherals.

---
 rtl/gpio_port_bank_pkg.sv | 21 ++
 rtl/gpio_port_bank_if.sv | 13 +
 rtl/gpio_port_slice.sv | 51 +++++
 rtl/gpio_port_bank.sv | 75 +++++++
 tb/tb_gpio_port_bank.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/gpio_port_bank_pkg.sv
// Shared constants and address helpers for the GPIO port bank.
// Default addresses follow the PIC16 midrange register map (PORTA/B, TRISA/B).
package gpio_bank_pkg;

  localparam logic [8:0] PORTA_ADDR = 9'h005;
  localparam logic [8:0] PORTB_ADDR = 9'h006;
  localparam logic [8:0] TRISA_ADDR = 9'h085;
  localparam logic [8:0] TRISB_ADDR = 9'h086;

  localparam int DEFAULT_NUM_PORTS = 2;
  localparam int DEFAULT_WIDTH     = 8;

  // 16F628A-style: only PORTB pins 7:4 have interrupt-on-change.
  localparam logic [15:0] PORTB_IOC_MASK = 16'hF000;

  // Offset of addr from a bank base; addresses below base wrap to large values and miss.
  function automatic logic [8:0] reg_offset(input logic [8:0] addr, input logic [8:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/gpio_port_bank_if.sv
// Peripheral bus between the core's extern_peripherals port and a peripheral block.
// Read data and hit are combinational from addr on the slave side.
interface gpio_port_bank_if;
  logic [8:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       hit;

  modport master (output addr, wr_en, rd_en, data_in, input data_out, hit);
  modport slave  (input addr, wr_en, rd_en, data_in, output data_out, hit);
endinterface

// File: rtl/gpio_port_slice.sv
// One GPIO port: TRIS and latch registers, two-flop pin synchroniser, IOC snapshot.
// Register writes land at the next edge; pin changes reach reads and IOC after two edges.
module gpio_port_slice #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MASK  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_port,
  input  logic             i_wr_tris,
  input  logic             i_rd_snap,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [WIDTH-1:0] i_pins,
  output logic [WIDTH-1:0] o_latch,
  output logic [WIDTH-1:0] o_tris,
  output logic [WIDTH-1:0] o_port_rd,
  output logic             o_ioc
);

  logic [WIDTH-1:0] r_latch;
  logic [WIDTH-1:0] r_tris;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_snap;
  logic [WIDTH-1:0] w_mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_latch <= '0;
      r_tris  <= '1;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_snap  <= '0;
    end else begin
      r_sync1 <= i_pins;
      r_sync2 <= r_sync1;
      if (i_wr_port) r_latch <= i_wdata;
      if (i_wr_tris) r_tris  <= i_wdata;
      // Snapshot takes the pre-edge synced value, so a change landing on this edge still mismatches.
      if (i_rd_snap) r_snap  <= r_sync2;
    end
  end

  assign w_mismatch = (r_sync2 ^ r_snap) & MASK & r_tris;

  assign o_latch   = r_latch;
  assign o_tris    = r_tris;
  assign o_port_rd = (r_tris & r_sync2) | (~r_tris & r_latch);
  assign o_ioc     = |w_mismatch;

endmodule

// File: rtl/gpio_port_bank.sv
// NUM_PORTS GPIO ports behind one address decoder on the core's external peripheral bus.
// Read mux and hit are combinational; per-port IOC strobes are level, held until the port is read.
module gpio_port_bank
  import gpio_bank_pkg::*;
#(
  parameter int                          NUM_PORTS      = DEFAULT_NUM_PORTS,
  parameter int                          WIDTH          = DEFAULT_WIDTH,
  parameter logic [8:0]                  PORT_BASE_ADDR = PORTA_ADDR,
  parameter logic [8:0]                  TRIS_BASE_ADDR = TRISA_ADDR,
  parameter logic [NUM_PORTS*WIDTH-1:0]  IOC_MASK       = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  gpio_port_bank_if.slave            bus,
  input  logic [NUM_PORTS*WIDTH-1:0] physical_in,
  output logic [NUM_PORTS*WIDTH-1:0] physical_out,
  output logic [NUM_PORTS*WIDTH-1:0] tris,
  output logic [NUM_PORTS-1:0]       ioc_strobe
);

  logic [8:0] w_port_off;
  logic [8:0] w_tris_off;
  logic       w_port_hit;
  logic       w_tris_hit;
  logic [7:0] w_port_rd [NUM_PORTS];
  logic [7:0] w_tris_rd [NUM_PORTS];

  assign w_port_off = reg_offset(bus.addr, PORT_BASE_ADDR);
  assign w_tris_off = reg_offset(bus.addr, TRIS_BASE_ADDR);
  assign w_port_hit = (w_port_off < 9'(NUM_PORTS));
  assign w_tris_hit = (w_tris_off < 9'(NUM_PORTS));

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
    logic             w_sel_port;
    logic             w_sel_tris;
    logic [WIDTH-1:0] w_rd;
    logic [WIDTH-1:0] w_tris;

    assign w_sel_port = w_port_hit && (w_port_off == 9'(n));
    assign w_sel_tris = w_tris_hit && (w_tris_off == 9'(n));

    gpio_port_slice #(
      .WIDTH (WIDTH),
      .MASK  (IOC_MASK[n*WIDTH +: WIDTH])
    ) u_slice (
      .clk       (clk),
      .rst       (rst),
      .i_wr_port (bus.wr_en & w_sel_port),
      .i_wr_tris (bus.wr_en & w_sel_tris),
      .i_rd_snap (bus.rd_en & w_sel_port),
      .i_wdata   (bus.data_in[WIDTH-1:0]),
      .i_pins    (physical_in[n*WIDTH +: WIDTH]),
      .o_latch   (physical_out[n*WIDTH +: WIDTH]),
      .o_tris    (w_tris),
      .o_port_rd (w_rd),
      .o_ioc     (ioc_strobe[n])
    );

    assign tris[n*WIDTH +: WIDTH] = w_tris;
    // Zero-extend to the 8-bit bus; upper bits read 0 for narrow ports.
    assign w_port_rd[n] = 8'(w_rd);
    assign w_tris_rd[n] = 8'(w_tris);
  end

  always_comb begin
    bus.data_out = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_port_hit && (w_port_off == 9'(i))) bus.data_out = w_port_rd[i];
      else if (w_tris_hit && (w_tris_off == 9'(i))) bus.data_out = w_tris_rd[i];
    end
  end

  assign bus.hit = w_port_hit | w_tris_hit;

endmodule

// File: tb/tb_gpio_port_bank.sv
// Directed bench for gpio_port_bank: two 8-bit ports, IOC on PORT1 pins 7:4.
module tb_gpio_port_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pins = 16'h0000;
  logic [15:0] pout;
  logic [15:0] ptris;
  logic [1:0]  ioc;
  int          total = 0;
  int          bad   = 0;

  gpio_port_bank_if bus();

  gpio_port_bank #(
    .NUM_PORTS      (2),
    .WIDTH          (8),
    .PORT_BASE_ADDR (9'h005),
    .TRIS_BASE_ADDR (9'h085),
    .IOC_MASK       (16'hF000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .physical_in  (pins),
    .physical_out (pout),
    .tris         (ptris),
    .ioc_strobe   (ioc)
  );

  always #5 clk = ~clk;

  task automatic do_write(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr = a; bus.data_in = d; bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [8:0] a);
    @(negedge clk);
    bus.addr = a; bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 9'h000; bus.data_in = 8'h00;
    repeat (2) @(negedge clk);
    total++; if (ptris !== 16'hFFFF) begin bad++; $display("FAIL reset_tris got=%h want=ffff", ptris); end
    total++; if (pout !== 16'h0000) begin bad++; $display("FAIL reset_out got=%h want=0000", pout); end
    total++; if (ioc !== 2'b00) begin bad++; $display("FAIL reset_ioc got=%b want=00", ioc); end
    bus.addr = 9'h085; #1;
    total++; if (bus.data_out !== 8'hFF) begin bad++; $display("FAIL reset_rd_tris got=%h want=ff", bus.data_out); end
    total++; if (bus.hit !== 1'b1) begin bad++; $display("FAIL reset_hit got=%b want=1", bus.hit); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_output();
    do_write(9'h086, 8'h00);
    bus.addr = 9'h006; bus.data_in = 8'hA5; bus.wr_en = 1'b1; #1;
    total++; if (pout[15:8] !== 8'h00) begin bad++; $display("FAIL out_before got=%h want=00", pout[15:8]); end
    @(negedge clk); bus.wr_en = 1'b0;
    total++; if (pout[15:8] !== 8'hA5) begin bad++; $display("FAIL out_after got=%h want=a5", pout[15:8]); end
    total++; if (ptris[15:8] !== 8'h00) begin bad++; $display("FAIL out_tris got=%h want=00", ptris[15:8]); end
    pins[15:8] = 8'h5A;
    repeat (3) @(negedge clk);
    total++; if (bus.data_out !== 8'hA5) begin bad++; $display("FAIL out_read got=%h want=a5", bus.data_out); end
  endtask

  task automatic test_input();
    @(negedge clk);
    pins[7:0] = 8'h3C; bus.addr = 9'h005; #1;
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL in_cyc0 got=%h want=00", bus.data_out); end
    @(negedge clk);
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL in_cyc1 got=%h want=00", bus.data_out); end
    @(negedge clk);
    total++; if (bus.data_out !== 8'h3C) begin bad++; $display("FAIL in_cyc2 got=%h want=3c", bus.data_out); end
    do_write(9'h085, 8'h0F);
    do_write(9'h005, 8'hF0);
    pins[7:0] = 8'h0A;
    repeat (3) @(negedge clk);
    bus.addr = 9'h005; #1;
    total++; if (bus.data_out !== 8'hFA) begin bad++; $display("FAIL in_mixed got=%h want=fa", bus.data_out); end
    total++; if (pout[7:0] !== 8'hF0) begin bad++; $display("FAIL in_latch got=%h want=f0", pout[7:0]); end
  endtask

  task automatic test_ioc();
    do_write(9'h086, 8'hFF);
    do_read(9'h006);
    total++; if (ioc !== 2'b00) begin bad++; $display("FAIL ioc_idle got=%b want=00", ioc); end
    pins[12] = ~pins[12]; #1;
    total++; if (ioc[1] !== 1'b0) begin bad++; $display("FAIL ioc_lat0 got=%b want=0", ioc[1]); end
    @(negedge clk);
    total++; if (ioc[1] !== 1'b0) begin bad++; $display("FAIL ioc_lat1 got=%b want=0", ioc[1]); end
    @(negedge clk);
    total++; if (ioc[1] !== 1'b1) begin bad++; $display("FAIL ioc_lat2 got=%b want=1", ioc[1]); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (ioc !== 2'b10) begin bad++; $display("FAIL ioc_hold%0d got=%b want=10", i, ioc); end
    end
    do_read(9'h006);
    total++; if (ioc[1] !== 1'b0) begin bad++; $display("FAIL ioc_clear got=%b want=0", ioc[1]); end
    pins[8] = ~pins[8];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (ioc[1] !== 1'b0) begin bad++; $display("FAIL ioc_unmasked%0d got=%b want=0", i, ioc[1]); end
    end
  endtask

  task automatic test_tris_mask();
    do_write(9'h086, 8'h0F);
    pins[12] = ~pins[12];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (ioc[1] !== 1'b0) begin bad++; $display("FAIL ioc_output%0d got=%b want=0", i, ioc[1]); end
    end
  endtask

  task automatic test_decode();
    @(negedge clk);
    bus.addr = 9'h007; bus.data_in = 8'hFF; bus.wr_en = 1'b1; bus.rd_en = 1'b1; #1;
    total++; if (bus.hit !== 1'b0) begin bad++; $display("FAIL dec_hit got=%b want=0", bus.hit); end
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL dec_data got=%h want=00", bus.data_out); end
    @(negedge clk);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    total++; if (pout !== 16'hA5F0) begin bad++; $display("FAIL dec_out got=%h want=a5f0", pout); end
    total++; if (ptris !== 16'h0F0F) begin bad++; $display("FAIL dec_tris got=%h want=0f0f", ptris); end
    bus.addr = 9'h087; #1;
    total++; if (bus.hit !== 1'b0) begin bad++; $display("FAIL dec_hit87 got=%b want=0", bus.hit); end
    bus.addr = 9'h004; #1;
    total++; if (bus.hit !== 1'b0) begin bad++; $display("FAIL dec_hit04 got=%b want=0", bus.hit); end
    bus.addr = 9'h086; #1;
    total++; if (bus.data_out !== 8'h0F) begin bad++; $display("FAIL dec_rd86 got=%h want=0f", bus.data_out); end
  endtask

  task automatic test_reset_write();
    @(negedge clk);
    rst = 1'b1; bus.addr = 9'h005; bus.data_in = 8'h55; bus.wr_en = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.wr_en = 1'b0;
    total++; if (pout !== 16'h0000) begin bad++; $display("FAIL rstwr_out got=%h want=0000", pout); end
    total++; if (ptris !== 16'hFFFF) begin bad++; $display("FAIL rstwr_tris got=%h want=ffff", ptris); end
    total++; if (ioc !== 2'b00) begin bad++; $display("FAIL rstwr_ioc got=%b want=00", ioc); end
    @(negedge clk);
    total++; if (pout !== 16'h0000) begin bad++; $display("FAIL rstwr_out2 got=%h want=0000", pout); end
  endtask

  // Pins 15:8 now hold 5B; the fresh snapshot is 0, so pins 12 and 14 mismatch.
  task automatic test_back_to_back();
    repeat (3) @(negedge clk);
    total++; if (ioc !== 2'b10) begin bad++; $display("FAIL b2b_pending got=%b want=10", ioc); end
    bus.addr = 9'h006; bus.data_in = 8'h3C; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    total++; if (ioc[1] !== 1'b0) begin bad++; $display("FAIL b2b_ioc got=%b want=0", ioc[1]); end
    total++; if (pout[15:8] !== 8'h3C) begin bad++; $display("FAIL b2b_latch got=%h want=3c", pout[15:8]); end
    #1;
    total++; if (bus.data_out !== 8'h5B) begin bad++; $display("FAIL b2b_read got=%h want=5b", bus.data_out); end
  endtask

  initial begin
    test_reset();
    test_output();
    test_input();
    test_ioc();
    test_tris_mask();
    test_decode();
    test_reset_write();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
